cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step sequencer sitting between the debug/operator panel and the 8-bit cpu core.
//  Owns the core's clk and rst pins: emits single clean clock pulses on demand.
//  Services RESET / RUN / STEP(n) / STOP commands.
//  Stops the core on halt, PC breakpoint, step exhaustion or operator STOP, and reports why.
// PARAMETERS
//  PC_WIDTH     8   width of cpu_pc and bp_addr
//  CNT_WIDTH    16  width of step argument and cycle counter
//  RESET_TICKS  2   cpu_clk pulses issued while cpu_rst is held (core reset is synchronous)
// PORTS
//  clk          in   1          system clock, single clock domain
//  rst          in   1          synchronous, active-high reset
//  cmd_valid    in   1          command strobe
//  cmd          in   2          0=RESET 1=RUN 2=STEP 3=STOP
//  cmd_arg      in   CNT_WIDTH  STEP count (0 treated as 1)
//  cmd_ready    out  1          high only in STOPPED; non-STOP command accepted on valid&&ready
//  bp_en        in   1          breakpoint enable
//  bp_addr      in   PC_WIDTH   breakpoint PC
//  cpu_halt     in   1          core halt flag
//  cpu_pc       in   PC_WIDTH   core pc
//  cpu_clk      out  1          clock to core; registered
//  cpu_rst      out  1          reset to core; registered
//  running      out  1          high in TICK_HI/TICK_LO
//  stop_reason  out  3          0 NONE 1 RESET_DONE 2 HALT 3 BREAK 4 CMD_STOP 5 STEPS_DONE
//  cycle_count  out  CNT_WIDTH  core ticks since last RESET_DONE, saturating at all-ones
// BEHAVIOUR
//  - States: RESET_HI, RESET_LO, STOPPED, TICK_HI, TICK_LO. All outputs registered.
//  - rst=1: next state RESET_HI, tick counter=RESET_TICKS.
//    Outputs: cpu_rst=1, cpu_clk=0, cmd_ready=0, running=0, stop_reason=NONE,
//    cycle_count=0, steps_left=0, mode=RUN, stop_req=0.
//  - rst mid-run takes effect the next edge: cpu_clk drops to 0; the sequence restarts from RESET_HI.
//  - RESET_HI: cpu_rst=1, cpu_clk=1 -> RESET_LO.
//  - RESET_LO: cpu_clk=0, cpu_rst=1, decrement tick counter.
//    If counter hits 0 -> STOPPED with cpu_rst=0, stop_reason=RESET_DONE, cycle_count=0.
//    Otherwise -> RESET_HI.
//  - STOPPED: cmd_ready=1.
//    RESET -> RESET_HI (counter reloaded).
//    RUN -> TICK_HI, mode=RUN.
//    STEP -> TICK_HI, mode=STEP, steps_left=max(cmd_arg,1).
//    STOP -> ignored (no state change).
//    Acceptance at edge k gives cpu_clk=1 during cycle k+1.
//  - TICK_HI: cpu_clk=1 for exactly one clk cycle.
//    cycle_count+=1, saturating. If mode=STEP, steps_left-=1.
//    -> TICK_LO.
//  - TICK_LO: cpu_clk=0 for one cycle; cpu_pc/cpu_halt sampled here (settled post-edge).
//    Stop conditions, highest priority first:
//      HALT (cpu_halt=1)
//      BREAK (bp_en && cpu_pc==bp_addr)
//      CMD_STOP (stop_req)
//      STEPS_DONE (mode=STEP && steps_left==0)
//    Any condition -> STOPPED, stop_reason set, stop_req cleared. None -> TICK_HI.
//  - STOP while running: cmd_valid&&cmd==STOP in TICK_HI/TICK_LO sets stop_req.
//    Other commands while running are dropped (cmd_ready=0). A pulse is never truncated.
//  - Breakpoint is checked only after a tick, so RUN from pc==bp_addr always advances >=1 instruction.
//  - cpu_clk duty: 1 high / 1 low; no two consecutive high cycles ever.
//  - cycle_count holds at all-ones once saturated; cleared only by a completed reset sequence.
// STRUCTURE
//  - Package cpu_ctrl_pkg: cmd_e (RESET/RUN/STEP/STOP), stop_reason_e, state_e,
//    and the 2-bit CMD_* / 3-bit STOP_* localparams shared with the panel encoder.
//  - Single module, no sub-modules.
//  - One always @(posedge clk) block: state, counters, registered outputs.
// TESTING
//  - Reset test: rst high 1 cycle, RESET_TICKS=2.
//    Expect cpu_rst=1 across exactly 2 cpu_clk pulses, then cmd_ready=1, stop_reason=1, cycle_count=0.
//  - STEP test: STEP arg=3, core model pc+=1.
//    Expect exactly 3 one-cycle cpu_clk pulses, stop_reason=5, cycle_count=3, cmd_ready back at 1.
//  - STEP arg=0: expect exactly 1 pulse, stop_reason=5.
//  - Breakpoint test: RUN with bp_en=1, bp_addr=8'h05, pc from 0.
//    Expect stop after the 5th pulse, stop_reason=3.
//    Re-RUN: expect >=1 pulse before any stop (pc 6).
//  - STOP test: RUN, then STOP on the cycle cpu_clk=1.
//    Expect that pulse to complete, no further pulse, stop_reason=4.
//  - Priority test: cpu_halt=1 and pc==bp_addr on the same tick -> stop_reason=2.
//    cpu_halt=1 before RUN -> exactly 1 pulse, then stop_reason=2.
//  - rst mid-run: expect cpu_clk=0 next cycle, reset sequence replays, RUN/STEP commands dropped until cmd_ready.
//    Saturation: CNT_WIDTH=4 RUN for 20 ticks -> cycle_count=15.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu run/step sequencer and the panel command encoder.
package cpu_ctrl_pkg;

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_STEP  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    localparam logic [2:0] STOP_NONE       = 3'd0;
    localparam logic [2:0] STOP_RESET_DONE = 3'd1;
    localparam logic [2:0] STOP_HALT       = 3'd2;
    localparam logic [2:0] STOP_BREAK      = 3'd3;
    localparam logic [2:0] STOP_CMD_STOP   = 3'd4;
    localparam logic [2:0] STOP_STEPS_DONE = 3'd5;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        STOP  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        SR_NONE       = 3'd0,
        SR_RESET_DONE = 3'd1,
        SR_HALT       = 3'd2,
        SR_BREAK      = 3'd3,
        SR_CMD_STOP   = 3'd4,
        SR_STEPS_DONE = 3'd5
    } stop_reason_e;

    typedef enum logic [2:0] {
        ST_RESET_HI = 3'd0,
        ST_RESET_LO = 3'd1,
        ST_STOPPED  = 3'd2,
        ST_TICK_HI  = 3'd3,
        ST_TICK_LO  = 3'd4
    } state_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

    // Post-tick stop decision, highest priority first.
    function automatic stop_reason_e tick_stop_reason(input logic halt, input logic brk,
                                                      input logic stop_req, input logic steps_done);
        if (halt)            return SR_HALT;
        else if (brk)        return SR_BREAK;
        else if (stop_req)   return SR_CMD_STOP;
        else if (steps_done) return SR_STEPS_DONE;
        else                 return SR_NONE;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: drives the 8-bit core's clock and reset as single clean pulses
// and stops the core on halt, breakpoint, step exhaustion or operator STOP.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned RESET_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    input  logic [CNT_WIDTH-1:0] cmd_arg,
    output logic                 cmd_ready,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic                 cpu_halt,
    input  logic [PC_WIDTH-1:0]  cpu_pc,
    output logic                 cpu_clk,
    output logic                 cpu_rst,
    output logic                 running,
    output logic [2:0]           stop_reason,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned TICK_W = (RESET_TICKS < 2) ? 1 : $clog2(RESET_TICKS + 1);
    localparam logic [TICK_W-1:0]    TICK_LOAD = TICK_W'(RESET_TICKS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_e                 state;
    mode_e                  mode;
    logic [TICK_W-1:0]      tick_cnt;
    logic [CNT_WIDTH-1:0]   steps_left;
    logic                   stop_req;

    logic                   stop_cmd_c;
    logic                   brk_hit_c;
    logic                   steps_done_c;
    stop_reason_e           reason_c;

    assign stop_cmd_c   = cmd_valid && (cmd == CMD_STOP);
    assign brk_hit_c    = bp_en && (cpu_pc == bp_addr);
    assign steps_done_c = (mode == MODE_STEP) && (steps_left == '0);
    assign reason_c     = tick_stop_reason(cpu_halt, brk_hit_c, stop_req, steps_done_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RESET_HI;
            tick_cnt    <= TICK_LOAD;
            cpu_rst     <= 1'b1;
            cpu_clk     <= 1'b0;
            cmd_ready   <= 1'b0;
            running     <= 1'b0;
            stop_reason <= SR_NONE;
            cycle_count <= '0;
            steps_left  <= '0;
            mode        <= MODE_RUN;
            stop_req    <= 1'b0;
        end else begin
            case (state)
                ST_RESET_HI: begin
                    cpu_rst <= 1'b1;
                    cpu_clk <= 1'b1;
                    state   <= ST_RESET_LO;
                end

                ST_RESET_LO: begin
                    cpu_clk  <= 1'b0;
                    tick_cnt <= tick_cnt - TICK_W'(1);
                    // A zero load is treated like one so the core always sees a reset edge.
                    if (tick_cnt <= TICK_W'(1)) begin
                        state       <= ST_STOPPED;
                        cpu_rst     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        stop_reason <= SR_RESET_DONE;
                        cycle_count <= '0;
                    end else begin
                        state <= ST_RESET_HI;
                    end
                end

                ST_STOPPED: begin
                    if (cmd_valid) begin
                        case (cmd_e'(cmd))
                            RESET: begin
                                state       <= ST_RESET_HI;
                                tick_cnt    <= TICK_LOAD;
                                cpu_rst     <= 1'b1;
                                cmd_ready   <= 1'b0;
                                stop_reason <= SR_NONE;
                            end
                            RUN: begin
                                state       <= ST_TICK_HI;
                                mode        <= MODE_RUN;
                                cpu_clk     <= 1'b1;
                                running     <= 1'b1;
                                cmd_ready   <= 1'b0;
                                stop_reason <= SR_NONE;
                            end
                            STEP: begin
                                state       <= ST_TICK_HI;
                                mode        <= MODE_STEP;
                                steps_left  <= (cmd_arg == '0) ? CNT_WIDTH'(1) : cmd_arg;
                                cpu_clk     <= 1'b1;
                                running     <= 1'b1;
                                cmd_ready   <= 1'b0;
                                stop_reason <= SR_NONE;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_TICK_HI: begin
                    cpu_clk <= 1'b0;
                    state   <= ST_TICK_LO;
                    if (cycle_count != CNT_MAX)
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    if (mode == MODE_STEP && steps_left != '0)
                        steps_left <= steps_left - CNT_WIDTH'(1);
                    if (stop_cmd_c)
                        stop_req <= 1'b1;
                end

                ST_TICK_LO: begin
                    // Core outputs have settled a full cycle after its clock edge.
                    if (reason_c != SR_NONE) begin
                        state       <= ST_STOPPED;
                        stop_reason <= reason_c;
                        stop_req    <= 1'b0;
                        cmd_ready   <= 1'b1;
                        running     <= 1'b0;
                    end else begin
                        state   <= ST_TICK_HI;
                        cpu_clk <= 1'b1;
                        if (stop_cmd_c)
                            stop_req <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_RESET_HI;
                    tick_cnt <= TICK_LOAD;
                    cpu_rst  <= 1'b1;
                    cpu_clk  <= 1'b0;
                    running  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: counter-based core model, vector table, random ops vs a stop-rule model.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        cmd_ready;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'd0;
    logic        cpu_halt = 1'b0;
    logic [7:0]  cpu_pc;
    logic        cpu_clk, cpu_rst, running;
    logic [2:0]  stop_reason;
    logic [15:0] cycle_count;

    logic        s_cmd_valid = 1'b0;
    logic [1:0]  s_cmd = 2'd0;
    logic [3:0]  s_cmd_arg = 4'd0;
    logic        s_cmd_ready;
    logic [7:0]  s_cpu_pc;
    logic        s_cpu_clk, s_cpu_rst, s_running;
    logic [2:0]  s_stop_reason;
    logic [3:0]  s_cycle_count;

    cpu_run_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(16), .RESET_TICKS(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_halt(cpu_halt),
        .cpu_pc(cpu_pc), .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .running(running),
        .stop_reason(stop_reason), .cycle_count(cycle_count)
    );

    cpu_run_ctrl #(.PC_WIDTH(8), .CNT_WIDTH(4), .RESET_TICKS(2)) dut_sat (
        .clk(clk), .rst(rst), .cmd_valid(s_cmd_valid), .cmd(s_cmd), .cmd_arg(s_cmd_arg),
        .cmd_ready(s_cmd_ready), .bp_en(1'b1), .bp_addr(8'd20), .cpu_halt(1'b0),
        .cpu_pc(s_cpu_pc), .cpu_clk(s_cpu_clk), .cpu_rst(s_cpu_rst), .running(s_running),
        .stop_reason(s_stop_reason), .cycle_count(s_cycle_count)
    );

    // Core models: pc clears on a reset edge, otherwise advances one per pulse.
    logic [7:0] pc = 8'd0;
    logic [7:0] s_pc = 8'd0;
    always @(posedge cpu_clk)   pc   <= cpu_rst   ? 8'd0 : pc + 8'd1;
    always @(posedge s_cpu_clk) s_pc <= s_cpu_rst ? 8'd0 : s_pc + 8'd1;
    assign cpu_pc   = pc;
    assign s_cpu_pc = s_pc;

    int pulse_cnt = 0, rst_pulse_cnt = 0, dbl_cnt = 0;
    logic prev_clk = 1'b0;
    always @(negedge clk) begin
        if (cpu_clk) begin
            pulse_cnt++;
            if (cpu_rst)  rst_pulse_cnt++;
            if (prev_clk) dbl_cnt++;
        end
        prev_clk = cpu_clk;
    end

    int n_checks = 0, n_fail = 0;
    int p0 = 0, r0 = 0;
    int cc_m = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] a);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", int'(cmd_ready), 1);
        p0 = pulse_cnt;
        r0 = rst_pulse_cnt;
        cmd_valid = 1'b1;
        cmd = c;
        cmd_arg = a;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < bound);
        #1;
        check("wait_ready", int'(cmd_ready), 1);
    endtask

    task automatic do_reset();
        send(CMD_RESET, 16'd0);
        wait_ready(50);
        check("rst_pulses", rst_pulse_cnt - r0, 2);
        check("rst_all_pulses", pulse_cnt - p0, 2);
        check("rst_reason", int'(stop_reason), 1);
        check("rst_cycle_count", int'(cycle_count), 0);
        check("rst_pc", int'(pc), 0);
        cc_m = 0;
    endtask

    // Stop rule: first tick k after which any condition holds, highest priority reported.
    function automatic void predict(input logic [1:0] c, input int arg, input bit bpen, input int bp,
                                    input bit halt, input int pc0, output int np, output int rs);
        int lim = (arg == 0) ? 1 : arg;
        np = -1;
        rs = 0;
        for (int k = 1; k <= 70000; k++) begin
            int p = (pc0 + k) % 256;
            if (halt)                                 begin np = k; rs = 2; return; end
            if (bpen && p == bp)                      begin np = k; rs = 3; return; end
            if (c == CMD_STEP && k >= lim)            begin np = k; rs = 5; return; end
        end
    endfunction

    typedef struct {
        logic [1:0]  c;
        logic [15:0] arg;
        logic        bpen;
        logic [7:0]  bp;
        logic        halt;
        int          exp_p;
        int          exp_r;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{CMD_STEP, 16'd3,  1'b0, 8'd0, 1'b0, 3, 5};
        tbl[1] = '{CMD_STEP, 16'd0,  1'b0, 8'd0, 1'b0, 1, 5};
        tbl[2] = '{CMD_RUN,  16'd0,  1'b1, 8'h05, 1'b0, 5, 3};
        tbl[3] = '{CMD_RUN,  16'd0,  1'b0, 8'd0, 1'b1, 1, 2};
        tbl[4] = '{CMD_RUN,  16'd0,  1'b1, 8'd1, 1'b1, 1, 2};
        tbl[5] = '{CMD_STEP, 16'd4,  1'b1, 8'd4, 1'b0, 4, 3};
        tbl[6] = '{CMD_STEP, 16'd10, 1'b1, 8'd4, 1'b0, 4, 3};
        tbl[7] = '{CMD_STEP, 16'd1,  1'b0, 8'd0, 1'b0, 1, 5};

        // Power-on reset
        @(negedge clk);
        rst = 1'b0;
        check("por_cpu_rst", int'(cpu_rst), 1);
        check("por_cpu_clk", int'(cpu_clk), 0);
        check("por_cmd_ready", int'(cmd_ready), 0);
        check("por_running", int'(running), 0);
        check("por_reason", int'(stop_reason), 0);
        check("por_cycle_count", int'(cycle_count), 0);
        wait_ready(50);
        check("por_pulses", pulse_cnt, 2);
        check("por_rst_pulses", rst_pulse_cnt, 2);
        check("por_done_reason", int'(stop_reason), 1);
        check("por_done_cpu_rst", int'(cpu_rst), 0);

        // Vector table, each from a fresh core reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bp_en = tbl[i].bpen;
            bp_addr = tbl[i].bp;
            cpu_halt = tbl[i].halt;
            send(tbl[i].c, tbl[i].arg);
            wait_ready(600);
            check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, tbl[i].exp_p);
            check($sformatf("vec%0d_reason", i), int'(stop_reason), tbl[i].exp_r);
            check($sformatf("vec%0d_cycles", i), int'(cycle_count), tbl[i].exp_p);
            check($sformatf("vec%0d_running", i), int'(running), 0);
            cpu_halt = 1'b0;
        end

        // Re-RUN from the breakpoint PC must advance before the breakpoint can fire again
        do_reset();
        bp_en = 1'b1;
        bp_addr = 8'h05;
        send(CMD_RUN, 16'd0);
        wait_ready(600);
        check("bp_first_pulses", pulse_cnt - p0, 5);
        send(CMD_RUN, 16'd0);
        wait_ready(1200);
        check("bp_rerun_pulses", pulse_cnt - p0, 256);
        check("bp_rerun_reason", int'(stop_reason), 3);
        check("bp_rerun_pc", int'(pc), 5);
        check("bp_rerun_cycles", int'(cycle_count), 261);

        // Operator STOP issued during a high pulse
        begin
            int n = 0;
            do_reset();
            bp_en = 1'b0;
            send(CMD_RUN, 16'd0);
            #1;
            while (pulse_cnt - p0 < 3 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("stop_on_high", int'(cpu_clk), 1);
            check("stop_running", int'(running), 1);
            cmd_valid = 1'b1;
            cmd = CMD_STOP;
            @(negedge clk);
            cmd_valid = 1'b0;
            wait_ready(50);
            check("stop_pulses", pulse_cnt - p0, 3);
            check("stop_reason", int'(stop_reason), 4);
        end

        // Commands other than STOP are dropped while running
        do_reset();
        bp_en = 1'b1;
        bp_addr = 8'd8;
        send(CMD_RUN, 16'd0);
        cmd_valid = 1'b1;
        cmd = CMD_STEP;
        cmd_arg = 16'd1;
        repeat (4) @(negedge clk);
        cmd_valid = 1'b0;
        wait_ready(100);
        check("drop_pulses", pulse_cnt - p0, 8);
        check("drop_reason", int'(stop_reason), 3);

        // rst mid-run: clock drops at once, reset replays, RUN ignored until ready
        begin
            int n = 0;
            do_reset();
            bp_en = 1'b0;
            send(CMD_RUN, 16'd0);
            #1;
            while (pulse_cnt - p0 < 2 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_cpu_clk", int'(cpu_clk), 0);
            check("midrst_cpu_rst", int'(cpu_rst), 1);
            check("midrst_running", int'(running), 0);
            p0 = pulse_cnt;
            r0 = rst_pulse_cnt;
            cmd_valid = 1'b1;
            cmd = CMD_RUN;
            repeat (3) @(negedge clk);
            cmd_valid = 1'b0;
            wait_ready(50);
            check("midrst_rst_pulses", rst_pulse_cnt - r0, 2);
            check("midrst_pulses", pulse_cnt - p0, 2);
            check("midrst_reason", int'(stop_reason), 1);
            check("midrst_cycles", int'(cycle_count), 0);
            p0 = pulse_cnt;
            repeat (6) @(negedge clk);
            #1;
            check("midrst_no_run", pulse_cnt - p0, 0);
            check("midrst_ready", int'(cmd_ready), 1);
        end

        // Randomized operations against the stop-rule model
        do_reset();
        for (int i = 0; i < 24; i++) begin
            int sel = int'($urandom_range(0, 9));
            int arg = int'($urandom_range(0, 40));
            bit bpe = 1'($urandom_range(0, 1));
            int bpa = int'($urandom_range(0, 255));
            bit hlt = ($urandom_range(0, 5) == 0);
            logic [1:0] c = (sel < 4) ? CMD_RUN : (sel < 9) ? CMD_STEP : CMD_STOP;
            int np, rs;
            if (c == CMD_RUN) bpe = 1'b1;
            bp_en = bpe;
            bp_addr = 8'(bpa);
            cpu_halt = hlt;
            if (c == CMD_STOP) begin
                send(CMD_STOP, 16'd0);
                repeat (3) @(negedge clk);
                #1;
                check($sformatf("rnd%0d_stop_idle", i), pulse_cnt - p0, 0);
                check($sformatf("rnd%0d_stop_ready", i), int'(cmd_ready), 1);
            end else begin
                predict(c, arg, bpe, bpa, hlt, int'(pc), np, rs);
                send(c, 16'(arg));
                wait_ready(1200);
                cc_m += np;
                check($sformatf("rnd%0d_pulses", i), pulse_cnt - p0, np);
                check($sformatf("rnd%0d_reason", i), int'(stop_reason), rs);
                check($sformatf("rnd%0d_cycles", i), int'(cycle_count), cc_m);
            end
            cpu_halt = 1'b0;
        end

        // Saturating counter on a 4-bit instance: 20 ticks to breakpoint 20
        begin
            int n = 0;
            @(negedge clk);
            check("sat_ready_before", int'(s_cmd_ready), 1);
            s_cmd_valid = 1'b1;
            s_cmd = CMD_RUN;
            @(negedge clk);
            s_cmd_valid = 1'b0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_cmd_ready && n < 200);
            check("sat_ready_after", int'(s_cmd_ready), 1);
            check("sat_cycles", int'(s_cycle_count), 15);
            check("sat_reason", int'(s_stop_reason), 3);
            check("sat_pc", int'(s_pc), 20);
        end

        check("no_double_high", dbl_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
